// File: rtl/param_seq_multiplier.sv
// Shift-add sequential multiplier: one multiplier bit per CALC cycle, valid/ready on both sides.
// Optional macro PARAM_SEQ_MULTIPLIER_EARLY_TERM_EN ends CALC once the remaining multiplier bits are zero.
module param_seq_multiplier #(
  parameter int WIDTH  = 16,
  parameter int SIGNED = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [PW-1:0]    mcand_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    prod_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] a_mag_d;
  logic [WIDTH-1:0] b_mag_d;
  logic             neg_d;
  logic [PW-1:0]    acc_d;
  logic [PW-1:0]    result_d;
  logic             last_d;

  // Operand magnitudes; -2^(WIDTH-1) negates to itself, which reads correctly as unsigned.
  always_comb begin
    if (SIGNED != 0) begin
      if (a[WIDTH-1]) begin
        a_mag_d = '0 - a;
      end else begin
        a_mag_d = a;
      end
      if (b[WIDTH-1]) begin
        b_mag_d = '0 - b;
      end else begin
        b_mag_d = b;
      end
      neg_d = a[WIDTH-1] ^ b[WIDTH-1];
    end else begin
      a_mag_d = a;
      b_mag_d = b;
      neg_d   = 1'b0;
    end
  end

  // Accumulate step, signed fix-up of the final sum and end-of-CALC detection.
  always_comb begin
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end else begin
      acc_d = acc_q;
    end
    if (neg_q) begin
      result_d = '0 - acc_d;
    end else begin
      result_d = acc_d;
    end
`ifdef PARAM_SEQ_MULTIPLIER_EARLY_TERM_EN
    last_d = (mplier_q[WIDTH-1:1] == '0) || (cnt_q == CW'(WIDTH - 1));
`else
    last_d = (cnt_q == CW'(WIDTH - 1));
`endif
  end

  // Control FSM with datapath registers and registered handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q    <= {{WIDTH{1'b0}}, a_mag_d};
            mplier_q   <= b_mag_d;
            acc_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= neg_d;
            state_q    <= CALC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= {mcand_q[PW-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
          cnt_q    <= cnt_q + 1'b1;
          if (last_d) begin
            prod_q      <= result_d;
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            state_q <= CALC;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign prod      = prod_q;

endmodule

// File: tb/tb_param_seq_multiplier.sv
// Self-checking bench for param_seq_multiplier: directed WIDTH=16 vectors plus random
// streams on WIDTH 2/8/16/33 in both signedness modes against a direct-multiply model.
module tb_param_seq_multiplier;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rnd_done = 0;

`ifdef PARAM_SEQ_MULTIPLIER_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif
  localparam int NRND = 125;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mark_done();
    rnd_done++;
  endtask

  // Directed instances: index 0 unsigned, index 1 signed, both WIDTH=16.
  logic        dv_rst;
  logic        dv_in_valid[2];
  logic        dv_in_ready[2];
  logic        dv_out_valid[2];
  logic        dv_out_ready[2];
  logic        dv_busy[2];
  logic [15:0] dv_a[2];
  logic [15:0] dv_b[2];
  logic [31:0] dv_prod[2];

  for (genvar s = 0; s < 2; s++) begin : g_dv
    param_seq_multiplier #(.WIDTH(16), .SIGNED(s)) u_dut (
      .clk       (clk),
      .rst       (dv_rst),
      .in_valid  (dv_in_valid[s]),
      .in_ready  (dv_in_ready[s]),
      .a         (dv_a[s]),
      .b         (dv_b[s]),
      .out_valid (dv_out_valid[s]),
      .out_ready (dv_out_ready[s]),
      .prod      (dv_prod[s]),
      .busy      (dv_busy[s])
    );
  end

  task automatic do_op(input int s, input logic [15:0] x, input logic [15:0] y, input logic ordy,
                       output logic [31:0] p, output int lat);
    int t;
    @(negedge clk);
    dv_a[s] = x;
    dv_b[s] = y;
    dv_in_valid[s] = 1'b1;
    dv_out_ready[s] = ordy;
    t = 0;
    while (!dv_in_ready[s] && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    dv_in_valid[s] = 1'b0;
    lat = 0;
    while (!dv_out_valid[s] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    p = dv_prod[s];
  endtask

  initial begin : main
    logic [31:0] p;
    int lat;
    int cnt;
    int t;
    dv_rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      dv_in_valid[s] = 1'b0;
      dv_out_ready[s] = 1'b0;
      dv_a[s] = 16'h0000;
      dv_b[s] = 16'h0000;
    end
    #12;
    check("rst_in_ready", dv_in_ready[0], 1);
    check("rst_busy", dv_busy[0], 0);
    check("rst_out_valid", dv_out_valid[0], 0);
    check("rst_prod", dv_prod[0], 0);
    @(negedge clk);
    dv_rst = 1'b0;

    do_op(0, 16'hFFFF, 16'hFFFF, 1'b1, p, lat);
    check("ffff_prod", p, 32'hFFFE0001);
    check("ffff_lat", lat, 16);
    @(posedge clk);
    #1;
    check("ffff_pulse_width", dv_out_valid[0], 0);
    check("ffff_back_idle", dv_in_ready[0], 1);

    do_op(1, 16'h8000, 16'h8000, 1'b1, p, lat);
    check("s_min_min", p, 32'h40000000);
    check("s_min_min_lat", lat, 16);
    do_op(1, 16'hFFFF, 16'h0003, 1'b1, p, lat);
    check("s_m1_x3", p, 32'hFFFFFFFD);
    check("s_m1_x3_lat", lat, ET ? 2 : 16);
    do_op(1, 16'h7FFF, 16'h8000, 1'b1, p, lat);
    check("s_max_min", p, 32'hC0008000);

    // Consumer stalls in DONE while a new request is presented.
    do_op(0, 16'd7, 16'd9, 1'b0, p, lat);
    check("hold_prod", p, 32'd63);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      dv_a[0] = 16'd100;
      dv_b[0] = 16'd100;
      dv_in_valid[0] = 1'b1;
      if (dv_out_valid[0] && dv_prod[0] == 32'd63 && !dv_in_ready[0] && !dv_busy[0]) cnt++;
    end
    check("hold_stable_cycles", cnt, 10);
    @(negedge clk);
    dv_in_valid[0] = 1'b0;
    dv_out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check("release_out_valid", dv_out_valid[0], 0);
    check("release_in_ready", dv_in_ready[0], 1);
    check("release_prod_kept", dv_prod[0], 32'd63);
    @(posedge clk);
    #1;
    check("stray_not_taken", dv_busy[0], 0);

    // Asynchronous reset five cycles into CALC.
    @(negedge clk);
    dv_a[0] = 16'd1234;
    dv_b[0] = 16'd5678;
    dv_in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    dv_in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("calc_busy", dv_busy[0], 1);
    #1;
    dv_rst = 1'b1;
    #1;
    check("arst_busy", dv_busy[0], 0);
    check("arst_in_ready", dv_in_ready[0], 1);
    check("arst_out_valid", dv_out_valid[0], 0);
    check("arst_prod", dv_prod[0], 0);
    @(negedge clk);
    dv_rst = 1'b0;
    cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (dv_out_valid[0]) cnt++;
    end
    check("arst_no_result", cnt, 0);
    do_op(0, 16'd3, 16'd5, 1'b1, p, lat);
    check("after_rst_prod", p, 32'd15);
    check("after_rst_lat", lat, ET ? 3 : 16);

    do_op(0, 16'h1234, 16'h0001, 1'b1, p, lat);
    check("et_b1_prod", p, 32'h00001234);
    check("et_b1_lat", lat, ET ? 1 : 16);
    do_op(0, 16'h1234, 16'h0000, 1'b1, p, lat);
    check("et_b0_prod", p, 32'h00000000);
    check("et_b0_lat", lat, ET ? 1 : 16);
    do_op(0, 16'h1234, 16'h0100, 1'b1, p, lat);
    check("et_b100_prod", p, 32'h00123400);
    check("et_b100_lat", lat, ET ? 9 : 16);

    t = 0;
    while (rnd_done < 8 && t < 90000) begin
      @(negedge clk);
      t++;
    end
    check("rnd_all_done", rnd_done, 8);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  // Random back-to-back streams with random consumer back-pressure.
  for (genvar g = 0; g < 8; g++) begin : g_rnd
    localparam int W = (g % 4 == 0) ? 2 : (g % 4 == 1) ? 8 : (g % 4 == 2) ? 16 : 33;
    localparam int S = g / 4;
    logic           rst_r;
    logic           iv;
    logic           ir;
    logic           ov;
    logic           ordy;
    logic           bsy;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic [2*W-1:0] rp;
    logic [2*W-1:0] exp_q[$];

    param_seq_multiplier #(.WIDTH(W), .SIGNED(S)) u_dut (
      .clk       (clk),
      .rst       (rst_r),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (ra),
      .b         (rb),
      .out_valid (ov),
      .out_ready (ordy),
      .prod      (rp),
      .busy      (bsy)
    );

    initial begin : drv
      logic [63:0]    r1;
      logic [63:0]    r2;
      logic [2*W-1:0] ea;
      logic [2*W-1:0] eb;
      int t;
      rst_r = 1'b1;
      iv = 1'b0;
      ra = '0;
      rb = '0;
      repeat (2) @(negedge clk);
      rst_r = 1'b0;
      for (int i = 0; i < NRND; i++) begin
        @(negedge clk);
        r1 = {$urandom(), $urandom()};
        r2 = {$urandom(), $urandom()};
        ra = r1[W-1:0];
        rb = r2[W-1:0];
        iv = 1'b1;
        t = 0;
        while (!ir && t < 400) begin
          @(negedge clk);
          t++;
        end
        if (t >= 400) check("rnd_accept_timeout", t, 0);
        ea = (S != 0) ? {{W{ra[W-1]}}, ra} : {{W{1'b0}}, ra};
        eb = (S != 0) ? {{W{rb[W-1]}}, rb} : {{W{1'b0}}, rb};
        exp_q.push_back(ea * eb);
        @(posedge clk);
        #1;
        iv = 1'b0;
      end
    end

    initial begin : mon
      logic [2*W-1:0] e;
      int got;
      int t;
      int viol;
      int extra;
      ordy = 1'b0;
      got = 0;
      t = 0;
      viol = 0;
      while (got < NRND && t < 60000) begin
        @(negedge clk);
        t++;
        ordy = 1'($urandom_range(0, 1));
        if (bsy && (ov || ir)) viol++;
        if (ov && ordy) begin
          check("rnd_result_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("rnd_w%0d_s%0d", W, S), rp, e);
          end
          got++;
        end
      end
      check("rnd_count", got, NRND);
      extra = 0;
      ordy = 1'b1;
      repeat (60) begin
        @(negedge clk);
        if (ov) extra++;
      end
      check("rnd_no_duplicate", extra, 0);
      check("rnd_busy_exclusive", viol, 0);
      mark_done();
    end
  end

endmodule

// File: doc/param_seq_multiplier.md
PARAM_SEQ_MULTIPLIER -- requirements
Module: param_seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal range 2..64.
REQ-002 SHALL have parameter SIGNED, default 0: 0 = unsigned operands, 1 = two's-complement operands and product.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands a/b present.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  multiplicand.
REQ-008 SHALL have port b  input  WIDTH  multiplier.
REQ-009 SHALL have port out_valid  output  1  prod holds a finished result.
REQ-010 SHALL have port out_ready  input  1  consumer takes prod.
REQ-011 SHALL have port prod  output  2*WIDTH  product.
REQ-012 SHALL have port busy  output  1  high while a multiplication is in CALC.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; in_ready = (state==IDLE), busy = (state==CALC), out_valid = (state==DONE).
REQ-014 SHALL accept operands on a rising edge with in_valid && in_ready, latching a and b and moving IDLE->CALC; a/b are ignored at all other times.
REQ-015 SHALL, in CALC, process one multiplier bit per cycle (shift-add: add shifted multiplicand to accumulator when current multiplier bit is 1).
REQ-016 SHALL, with the early-termination feature absent, spend exactly WIDTH cycles in CALC; out_valid rises on the WIDTH-th edge after the acceptance edge.
REQ-017 SHALL, with SIGNED=1, multiply operand magnitudes and negate the 2*WIDTH result when sign(a) XOR sign(b) is 1 and the product is nonzero; magnitude of -2^(WIDTH-1) SHALL be handled as the unsigned value 2^(WIDTH-1).
REQ-018 SHALL produce the exact 2*WIDTH-bit product for every operand pair (no truncation or overflow); e.g. WIDTH=16 unsigned 0xFFFF*0xFFFF = 0xFFFE0001; signed 0x8000*0x8000 = 0x40000000.
REQ-019 SHALL hold prod and out_valid stable in DONE until an edge with out_ready=1, then go DONE->IDLE; in_ready rises the cycle after (no same-cycle bypass).
REQ-020 SHALL keep prod holding the last result after leaving DONE until the next result is written.
REQ-021 SHALL ignore out_ready outside DONE and in_valid outside IDLE.

Reset
REQ-022 SHALL, on rst assertion (asynchronous, including mid-CALC or in DONE), immediately force state IDLE, prod = 0, out_valid = 0, busy = 0, in_ready = 1, and discard any operation in progress.
REQ-023 SHALL clear internal accumulator, operand registers and bit counter to 0 on reset; first acceptance after rst deasserts SHALL behave as from power-up.

Configuration
REQ-024 SHALL support macro PARAM_SEQ_MULTIPLIER_EARLY_TERM_EN.
REQ-025 SHALL, with the macro defined, leave CALC on the edge after the remaining (unshifted) multiplier-magnitude bits become all zero; CALC duration = max(1, index of highest set bit of |b| + 1) cycles; b=0 SHALL take 1 cycle.
REQ-026 SHALL, without the macro, always take exactly WIDTH CALC cycles (REQ-016); results SHALL be identical in both builds.

Verification
REQ-027 SHALL cover: WIDTH=16 unsigned, a=0xFFFF, b=0xFFFF, out_ready=1 -> prod=0xFFFE0001, out_valid exactly 16 edges after acceptance, one cycle wide.
REQ-028 SHALL cover: WIDTH=16 SIGNED=1, pairs (0x8000,0x8000), (0xFFFF,0x0003), (0x7FFF,0x8000) -> 0x40000000, 0xFFFFFFFD, 0xC0008000.
REQ-029 SHALL cover: out_ready held 0 for 10 cycles in DONE -> prod/out_valid stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-030 SHALL cover: rst pulsed asynchronously 5 cycles into CALC -> outputs reset values immediately, no out_valid; next operation (3*5) -> prod=15.
REQ-031 SHALL cover: with PARAM_SEQ_MULTIPLIER_EARLY_TERM_EN, WIDTH=16 unsigned b=0x0001 -> 1 CALC cycle, b=0x0000 -> 1 cycle prod=0, b=0x0100 -> 9 cycles; without macro all take 16.
REQ-032 SHALL cover: 1000 random back-to-back operand pairs for WIDTH in {2,8,16,33}, both SIGNED values, random out_ready -> every prod matches reference model, no lost or duplicated results.
